scarv_cop_dispatch: RTL
=======================

// Module: scarv_cop_dispatch
// PURPOSE
//  Parametrised CPU/COP instruction sequencer and functional-unit dispatcher.
//  Accepts one instruction at a time over the req/ack + rsp/ack handshake.
//  Issues it to one of NFU functional units, selected one-hot by the decoder.
//  Captures the unit's result and GPR writeback; supports CPU abort mid-execution.
//  Sits between the CPU interface and the FU instances, replacing fixed-class dispatch glue.
// PARAMETERS
//  NFU     4    number of functional units (1..8)
//  WDT_W   8    watchdog counter width, SCARV_COP_DISPATCH_WATCHDOG_EN only
//  WDT_MAX 200  cycles in EXECUTING before forced timeout (< 2**WDT_W)
// PORTS
//  g_clk          in   1       global clock
//  g_reset        in   1       synchronous active-high reset
//  cpu_insn_req   in   1       instruction request
//  cop_insn_ack   out  1       request acknowledge
//  cpu_abort_req  in   1       abort in-flight instruction
//  cop_insn_rsp   out  1       instruction finished
//  cpu_insn_ack   in   1       finish acknowledge
//  id_exception   in   1       decoder: illegal instruction
//  id_fu_sel      in   NFU     decoder: one-hot target FU
//  id_rd          in   5       decoder: GPR destination
//  fu_ivalid      out  NFU     per-FU instruction valid
//  fu_abort       out  1       one-cycle FU flush pulse
//  fu_idone       in   NFU     per-FU done
//  fu_result      in   3*NFU   per-FU result code, FU i at [3i+2:3i]
//  fu_gpr_wen     in   NFU     per-FU GPR write request
//  fu_gpr_wdata   in   32*NFU  per-FU GPR write data
//  cop_wen        out  1       GPR write enable, registered
//  cop_waddr      out  5       GPR address, registered
//  cop_wdata      out  32      GPR data, registered
//  cop_result     out  3       result code (SCARV_COP_INSN_*), registered
// BEHAVIOUR
//  - Reset: state IDLE. cop_insn_ack, cop_insn_rsp, fu_ivalid, fu_abort,
//    cop_wen, cop_waddr, cop_wdata and cop_result are all 0.
//  - FSM (state register and ack/rsp registered):
//    - IDLE -> WAITING unconditionally; ack=1 from the following cycle.
//    - WAITING, accept (req&&ack): fin -> FINISHED with rsp=1, ack=0.
//      No fin -> EXECUTING with ack=0. Otherwise stay, ack=1.
//    - EXECUTING, abort: -> WAITING with ack=1, no rsp, outputs unchanged.
//      fin -> FINISHED with rsp=1. Otherwise stay.
//    - FINISHED, retire (rsp&&cpu_insn_ack): -> WAITING with ack=1.
//      Otherwise hold rsp=1. cpu_abort_req is ignored in FINISHED.
//  - Definitions used above:
//    - fin = |(fu_idone & id_fu_sel), or bad, or watchdog expiry.
//    - bad = (id_exception || id_fu_sel not exactly one-hot) && accept.
//      A bad instruction completes in its accept cycle.
//  - fu_ivalid = id_fu_sel & {NFU{(accept || EXECUTING) && !bad}}.
//  - fu_idone from non-selected FUs is ignored.
//  - fu_abort=1 for the single cycle in which EXECUTING sees abort.
//  - Abort has priority over fin in the same cycle.
//  - Capture on fin (one-cycle latency to the outputs):
//    - cop_result: SCARV_COP_INSN_BAD_INS if bad, watchdog code on expiry,
//      else the selected fu_result.
//    - cop_wen = selected fu_gpr_wen && !bad. cop_waddr = id_rd.
//    - cop_wdata = selected fu_gpr_wdata.
//  - CPU holds the instruction and decoder fields stable from accept until retire.
//  - Minimum latency: combinational FU gives rsp in the cycle after accept.
//    Back-to-back throughput is one instruction per 2 cycles.
//  - Reset asserted mid-operation returns to IDLE next edge; FUs see fu_ivalid=0.
// CONFIGURATION
//  SCARV_COP_DISPATCH_WATCHDOG_EN defined:
//  - WDT_W counter clears on accept and counts in EXECUTING.
//  - Reaching WDT_MAX forces fin with cop_result=3'b111 and cop_wen=0.
//  - fu_abort pulses in the same cycle.
//  Undefined: no counter; EXECUTING waits indefinitely for fu_idone.
// TESTING
//  - Comb FU: sel=0010, req with idone=1, result=0, gpr_wen=1, wdata=0xDEADBEEF, rd=5
//    -> rsp next cycle; cop_wen=1, waddr=5, wdata=0xDEADBEEF, result=0.
//  - Multi-cycle FU: sel=0001, idone 3 cycles after accept
//    -> fu_ivalid[0] high 4 cycles; rsp on cycle 4; ack=0 until retire.
//  - id_exception=1 at accept -> fu_ivalid=0, rsp next cycle, result=BAD_INS, cop_wen=0.
//  - id_fu_sel=0011 -> treated as bad; fu_ivalid=0; result=BAD_INS.
//  - Abort 2 cycles into EXECUTING -> fu_abort 1-cycle pulse; no rsp; ack=1 next cycle;
//    abort in FINISHED ignored.
//  - WATCHDOG_EN, WDT_MAX=10, FU never done -> rsp 11 cycles after accept, result=7.

Source files
------------

// File: rtl/scarv_cop_dispatch.sv
// Instruction sequencer and one-hot functional-unit dispatcher for the SCARV coprocessor.
// Optional watchdog timeout is enabled by defining SCARV_COP_DISPATCH_WATCHDOG_EN.
module scarv_cop_dispatch #(
  parameter int NFU     = 4,
  parameter int WDT_W   = 8,
  parameter int WDT_MAX = 200
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              cpu_insn_req,
  output logic              cop_insn_ack,
  input  logic              cpu_abort_req,
  output logic              cop_insn_rsp,
  input  logic              cpu_insn_ack,
  input  logic              id_exception,
  input  logic [NFU-1:0]    id_fu_sel,
  input  logic [4:0]        id_rd,
  output logic [NFU-1:0]    fu_ivalid,
  output logic              fu_abort,
  input  logic [NFU-1:0]    fu_idone,
  input  logic [3*NFU-1:0]  fu_result,
  input  logic [NFU-1:0]    fu_gpr_wen,
  input  logic [32*NFU-1:0] fu_gpr_wdata,
  output logic              cop_wen,
  output logic [4:0]        cop_waddr,
  output logic [31:0]       cop_wdata,
  output logic [2:0]        cop_result
);

  localparam logic [2:0] L_RES_BAD_INS = 3'b010;
  localparam logic [2:0] L_RES_WDT     = 3'b111;

  if (NFU < 1 || NFU > 8 || WDT_MAX < 1 || WDT_MAX >= (1 << WDT_W)) begin : g_param_check
    $error("scarv_cop_dispatch: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAITING, S_EXECUTING, S_FINISHED} state_t;

  state_t      r_state;
  logic        r_ack;
  logic        r_rsp;
  logic        r_wen;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic [2:0]  r_result;

  logic        w_accept;
  logic        w_exec;
  logic        w_bad;
  logic        w_fin;
  logic        w_wdt_expire;
  logic [2:0]  w_sel_result;
  logic        w_sel_wen;
  logic [31:0] w_sel_wdata;
  logic [2:0]  w_cap_result;
  logic        w_cap_wen;

  assign w_accept = cpu_insn_req && r_ack;
  assign w_exec   = (r_state == S_EXECUTING);
  assign w_bad    = (id_exception || !$onehot(id_fu_sel)) && w_accept;

`ifdef SCARV_COP_DISPATCH_WATCHDOG_EN
  localparam logic [WDT_W-1:0] L_WDT_LAST = WDT_W'(WDT_MAX - 1);
  logic [WDT_W-1:0] r_wdt;

  // Counter reads n-1 in the n-th EXECUTING cycle, so expiry lands on cycle WDT_MAX.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_wdt <= '0;
    end else if (w_accept) begin
      r_wdt <= '0;
    end else if (w_exec) begin
      r_wdt <= r_wdt + 1'b1;
    end
  end

  assign w_wdt_expire = w_exec && (r_wdt == L_WDT_LAST);
`else
  assign w_wdt_expire = 1'b0;
`endif

  assign w_fin = (|(fu_idone & id_fu_sel)) || w_bad || w_wdt_expire;

  // Gated by reset so FUs never see a stale issue while the FSM is being cleared.
  assign fu_ivalid = ((w_accept || w_exec) && !w_bad && !g_reset) ? id_fu_sel : '0;
  assign fu_abort  = w_exec && (cpu_abort_req || w_wdt_expire) && !g_reset;

  always_comb begin
    w_sel_result = '0;
    w_sel_wen    = 1'b0;
    w_sel_wdata  = '0;
    for (int i = 0; i < NFU; i++) begin
      if (id_fu_sel[i]) begin
        w_sel_result = w_sel_result | fu_result[3*i +: 3];
        w_sel_wen    = w_sel_wen | fu_gpr_wen[i];
        w_sel_wdata  = w_sel_wdata | fu_gpr_wdata[32*i +: 32];
      end
    end
  end

  assign w_cap_result = w_bad ? L_RES_BAD_INS : (w_wdt_expire ? L_RES_WDT : w_sel_result);
  assign w_cap_wen    = w_sel_wen && !w_bad && !w_wdt_expire;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_rsp    <= 1'b0;
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_WAITING;
          r_ack   <= 1'b1;
        end
        S_WAITING: begin
          if (w_accept) begin
            r_ack <= 1'b0;
            if (w_fin) begin
              r_state  <= S_FINISHED;
              r_rsp    <= 1'b1;
              r_result <= w_cap_result;
              r_wen    <= w_cap_wen;
              r_waddr  <= id_rd;
              r_wdata  <= w_sel_wdata;
            end else begin
              r_state <= S_EXECUTING;
            end
          end
        end
        S_EXECUTING: begin
          // Abort beats a simultaneous finish; captured outputs are left untouched.
          if (cpu_abort_req) begin
            r_state <= S_WAITING;
            r_ack   <= 1'b1;
          end else if (w_fin) begin
            r_state  <= S_FINISHED;
            r_rsp    <= 1'b1;
            r_result <= w_cap_result;
            r_wen    <= w_cap_wen;
            r_waddr  <= id_rd;
            r_wdata  <= w_sel_wdata;
          end
        end
        S_FINISHED: begin
          if (r_rsp && cpu_insn_ack) begin
            r_state <= S_WAITING;
            r_rsp   <= 1'b0;
            r_ack   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_rsp   <= 1'b0;
        end
      endcase
    end
  end

  assign cop_insn_ack = r_ack;
  assign cop_insn_rsp = r_rsp;
  assign cop_wen      = r_wen;
  assign cop_waddr    = r_waddr;
  assign cop_wdata    = r_wdata;
  assign cop_result   = r_result;

endmodule
